dijkstra_sequencer: RTL and testbench

DIJKSTRA_SEQUENCER -- requirements
Module: dijkstra_sequencer

---
 rtl/dijkstra_pkg.sv | 21 ++
 rtl/dijkstra_sequencer_phase_timer.sv | 30 +++
 rtl/dijkstra_sequencer.sv | 125 ++++++++++++
 tb/tb_dijkstra_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dijkstra_pkg.sv
// Shared types for the Dijkstra route engine: node ids, distances
// and the run sequencer state encoding.
package dijkstra_pkg;

  localparam int MAX_NODES_DEF = 15;
  localparam int NODE_W        = 9;
  localparam int DIST_W        = 14;
  localparam int RUN_W         = 24;

  typedef logic [NODE_W-1:0] node_id_t;
  typedef logic [DIST_W-1:0] dist_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TBL_INIT,
    S_SRC_INIT,
    S_LOOP,
    S_DONE
  } state_e;

endpackage

// File: rtl/dijkstra_sequencer_phase_timer.sv
// Per-phase watchdog: reloads on phase entry, flags when the phase
// has lasted LIMIT cycles.
module phase_timer #(
  parameter int LIMIT = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // cnt_q equals the 1-based cycle index within the current phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(1);
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/dijkstra_sequencer.sv
// Route-run sequencer: table init, source init, relaxation loop,
// with abort, per-phase timeout, run-length count and address muxing.
module dijkstra_sequencer
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES      = MAX_NODES_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  node_id_t                  req_start_id,
  output logic                      req_ready,
  input  logic                      abort,
  output logic                      tbl_init_start,
  input  logic                      tbl_init_done,
  output logic                      src_init_start,
  input  logic                      src_init_done,
  output logic                      loop_start,
  input  logic                      loop_done,
  output node_id_t                  start_id,
  input  node_id_t [MAX_NODES-1:0]  init_rd_addr,
  input  node_id_t [MAX_NODES-1:0]  loop_rd_addr,
  output node_id_t [MAX_NODES-1:0]  rd_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic [RUN_W-1:0]          run_cycles
);

  state_e           state_q, state_d;
  logic             accept, timed, expired, entry, time_up;
  logic             tbl_go_q, src_go_q, loop_go_q;
  logic             tbl_go_d, src_go_d, loop_go_d;
  logic [1:0]       sel_q, sel_d;
  node_id_t         start_id_q;
  logic             err_q;
  logic [RUN_W-1:0] cyc_q, run_q;

  assign accept  = req_valid && req_ready;
  assign timed   = state_q inside {S_TBL_INIT, S_SRC_INIT, S_LOOP};
  assign time_up = timed && expired && !abort;
  assign entry   = (state_d != state_q);

  phase_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (entry),
    .en_i     (timed),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A done is only honoured once its own start pulse has dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (accept) state_d = S_TBL_INIT;
      S_TBL_INIT: if (tbl_init_done && !tbl_go_q) state_d = S_SRC_INIT;
      S_SRC_INIT: if (src_init_done && !src_go_q) state_d = S_LOOP;
      S_LOOP:     if (loop_done && !loop_go_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (time_up) state_d = S_IDLE;
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && reset;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    tbl_go_d  = entry && (state_d == S_TBL_INIT);
    src_go_d  = entry && (state_d == S_SRC_INIT);
    loop_go_d = entry && (state_d == S_LOOP);
    sel_d     = {state_d == S_LOOP, state_d == S_SRC_INIT};
    rd_addr   = '0;
    unique case (1'b1)
      sel_q[0]: rd_addr = init_rd_addr;
      sel_q[1]: rd_addr = loop_rd_addr;
      default:  rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_go_q   <= 1'b0;
      src_go_q   <= 1'b0;
      loop_go_q  <= 1'b0;
      sel_q      <= '0;
      start_id_q <= '0;
      err_q      <= 1'b0;
      cyc_q      <= '0;
      run_q      <= '0;
    end else begin
      tbl_go_q  <= tbl_go_d;
      src_go_q  <= src_go_d;
      loop_go_q <= loop_go_d;
      sel_q     <= sel_d;
      if (accept) begin
        start_id_q <= req_start_id;
        err_q      <= 1'b0;
        cyc_q      <= RUN_W'(1);
      end else begin
        if (time_up) err_q <= 1'b1;
        if (timed && cyc_q != '1) cyc_q <= cyc_q + RUN_W'(1);
      end
      if (state_q == S_DONE) run_q <= cyc_q;
    end
  end

  assign tbl_init_start = tbl_go_q;
  assign src_init_start = src_go_q;
  assign loop_start     = loop_go_q;
  assign start_id       = start_id_q;
  assign timeout_err    = err_q;
  assign run_cycles     = run_q;

endmodule

// File: tb/tb_dijkstra_sequencer.sv
// Directed bench for dijkstra_sequencer: normal and back-to-back runs,
// stray/aborted dones, address mux, timeout and mid-run reset.
module tb_dijkstra_sequencer;
  import dijkstra_pkg::*;

  localparam int N = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic req_valid, req_ready, abort;
  node_id_t req_start_id, start_id;
  logic tbl_init_start, tbl_init_done;
  logic src_init_start, src_init_done;
  logic loop_start, loop_done;
  node_id_t [N-1:0] init_rd_addr, loop_rd_addr, rd_addr;
  logic busy, done, timeout_err;
  logic [23:0] run_cycles;

  logic req_valid_t, req_ready_t, abort_t;
  node_id_t start_id_t;
  logic tbl_init_start_t, tbl_done_t;
  logic src_init_start_t, src_done_t;
  logic loop_start_t, loop_done_t;
  node_id_t [N-1:0] rd_addr_t;
  logic busy_t, done_t, timeout_err_t;
  logic [23:0] run_cycles_t;

  logic tbl_stub = 1'b0, src_stub = 1'b0, loop_stub = 1'b0;
  logic loop_force = 1'b0;
  assign tbl_init_done = tbl_stub;
  assign src_init_done = src_stub;
  assign loop_done     = loop_stub | loop_force;

  dijkstra_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_start_id(req_start_id),
    .req_ready(req_ready), .abort(abort),
    .tbl_init_start(tbl_init_start), .tbl_init_done(tbl_init_done),
    .src_init_start(src_init_start), .src_init_done(src_init_done),
    .loop_start(loop_start), .loop_done(loop_done),
    .start_id(start_id),
    .init_rd_addr(init_rd_addr), .loop_rd_addr(loop_rd_addr),
    .rd_addr(rd_addr), .busy(busy), .done(done),
    .timeout_err(timeout_err), .run_cycles(run_cycles)
  );

  dijkstra_sequencer #(.TIMEOUT_CYCLES(100)) dut_t (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_t), .req_start_id(9'd1),
    .req_ready(req_ready_t), .abort(abort_t),
    .tbl_init_start(tbl_init_start_t), .tbl_init_done(tbl_done_t),
    .src_init_start(src_init_start_t), .src_init_done(src_done_t),
    .loop_start(loop_start_t), .loop_done(loop_done_t),
    .start_id(start_id_t),
    .init_rd_addr(init_rd_addr), .loop_rd_addr(loop_rd_addr),
    .rd_addr(rd_addr_t), .busy(busy_t), .done(done_t),
    .timeout_err(timeout_err_t), .run_cycles(run_cycles_t)
  );

  // Stub engines: answer done d_* cycles after seeing their start pulse
  int d_tbl, d_src, d_loop;
  int ct, cs, cl;
  always @(negedge clk) begin
    tbl_stub = 1'b0; src_stub = 1'b0; loop_stub = 1'b0;
    if (!reset) begin ct = 0; cs = 0; cl = 0; end
    if (ct > 0) begin ct--; tbl_stub = (ct == 0); end
    if (cs > 0) begin cs--; src_stub = (cs == 0); end
    if (cl > 0) begin cl--; loop_stub = (cl == 0); end
    if (tbl_init_start && d_tbl > 0) ct = d_tbl;
    if (src_init_start && d_src > 0) cs = d_src;
    if (loop_start && d_loop > 0) cl = d_loop;
  end

  int cyc, n_tbl, n_src, n_loop, n_done, n_done_t;
  int t_tbl, t_src, t_loop, t_done;
  int rdy_bad, sid_bad, mux_bad, mux_hits, ph;
  node_id_t exp_sid;
  node_id_t [N-1:0] exp_mux;
  always @(negedge clk) begin
    cyc++;
    if (tbl_init_start) begin n_tbl++; t_tbl = cyc; ph = 1; end
    if (src_init_start) begin n_src++; t_src = cyc; ph = 2; end
    if (loop_start) begin n_loop++; t_loop = cyc; ph = 3; end
    if (done) begin n_done++; t_done = cyc; ph = 4; end
    if (!busy) ph = 0;
    if (busy && req_ready) rdy_bad++;
    if (busy && start_id != exp_sid) sid_bad++;
    exp_mux = (ph == 2) ? init_rd_addr :
              (ph == 3) ? loop_rd_addr : '0;
    if (rd_addr !== exp_mux) mux_bad++;
    if (ph == 2 || ph == 3) mux_hits++;
    if (done_t) n_done_t++;
  end

  int n_vec, n_err;
  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_for(input string tag, input int sel, input int lim);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? tbl_init_start :
            (sel == 1) ? src_init_start :
            (sel == 2) ? loop_start : done;
    end
    chk({tag, "_seen"}, 32'(hit), 1);
  endtask

  int b_tbl, b_src, b_loop, b_done, n;

  initial begin
    reset = 1'b0; abort = 1'b0; req_valid = 1'b0; req_start_id = '0;
    req_valid_t = 1'b0; abort_t = 1'b0;
    tbl_done_t = 1'b0; src_done_t = 1'b0; loop_done_t = 1'b0;
    d_tbl = 20; d_src = 30; d_loop = 200;
    exp_sid = '0;
    for (int i = 0; i < N; i++) begin
      init_rd_addr[i] = 9'(i * 7 + 3);
      loop_rd_addr[i] = 9'(511 - i * 11);
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rd_zero", 32'(rd_addr == '0), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_start_id", 32'(start_id), 0);
    chk("rel_run_cycles", 32'(run_cycles), 0);
    chk("rel_timeout_err", 32'(timeout_err), 0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_ready", 32'(req_ready), 1);

    // normal run id 0, then id 5 held pending while busy
    b_tbl = n_tbl; b_src = n_src; b_loop = n_loop; b_done = n_done;
    req_valid = 1'b1; req_start_id = 9'd0;
    @(negedge clk);
    chk("run1_busy", 32'(busy), 1);
    chk("run1_tbl_pulse", 32'(tbl_init_start), 1);
    req_start_id = 9'd5;
    wait_for("run1_done", 3, 400);
    chk("run1_ready_at_done", 32'(req_ready), 0);
    @(negedge clk);
    exp_sid = 9'd5;
    chk("run1_done_width", 32'(done), 0);
    chk("run1_idle_ready", 32'(req_ready), 1);
    chk("run1_cycles", 32'(run_cycles >= 24'd250 && run_cycles <= 24'd256), 1);
    chk("run1_tbl_cnt", 32'(n_tbl - b_tbl), 1);
    chk("run1_src_cnt", 32'(n_src - b_src), 1);
    chk("run1_loop_cnt", 32'(n_loop - b_loop), 1);
    chk("run1_done_cnt", 32'(n_done - b_done), 1);
    chk("run1_order", 32'(t_tbl < t_src && t_src < t_loop && t_loop < t_done), 1);
    chk("run1_sid_hold", 32'(sid_bad), 0);
    chk("ready_while_busy", 32'(rdy_bad), 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("run2_busy", 32'(busy), 1);
    chk("run2_start_id", 32'(start_id), 5);
    chk("run2_tbl_pulse", 32'(tbl_init_start), 1);
    wait_for("run2_done", 3, 400);
    @(negedge clk);
    chk("run2_cycles", 32'(run_cycles >= 24'd250 && run_cycles <= 24'd256), 1);

    // stray loop_done in SRC_INIT, then abort coinciding with loop_done
    d_tbl = 3; d_src = 10; d_loop = 0;
    exp_sid = 9'd9;
    @(negedge clk);
    req_valid = 1'b1; req_start_id = 9'd9;
    @(negedge clk);
    req_valid = 1'b0;
    wait_for("ab_src", 1, 50);
    b_loop = n_loop;
    @(negedge clk);
    loop_force = 1'b1;
    @(negedge clk);
    loop_force = 1'b0;
    chk("stray_busy", 32'(busy), 1);
    chk("stray_no_loop", 32'(n_loop - b_loop), 0);
    wait_for("ab_loop", 2, 50);
    b_done = n_done;
    repeat (3) @(negedge clk);
    abort = 1'b1; loop_force = 1'b1;
    @(negedge clk);
    abort = 1'b0; loop_force = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(timeout_err), 0);
    chk("abort_ready", 32'(req_ready), 1);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(n_done - b_done), 0);

    // asynchronous reset while in SRC_INIT
    d_tbl = 3; d_src = 50; d_loop = 0;
    exp_sid = 9'd7;
    req_valid = 1'b1; req_start_id = 9'd7;
    @(negedge clk);
    req_valid = 1'b0;
    wait_for("mr_src", 1, 50);
    b_done = n_done;
    #2 reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_ready", 32'(req_ready), 0);
    chk("mr_pulses", 32'({tbl_init_start, src_init_start, loop_start}), 0);
    chk("mr_start_id", 32'(start_id), 0);
    chk("mr_run_cycles", 32'(run_cycles), 0);
    chk("mr_err", 32'(timeout_err), 0);
    chk("mr_rd_zero", 32'(rd_addr == '0), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rel_ready", 32'(req_ready), 1);
    d_tbl = 2; d_src = 2; d_loop = 2;
    exp_sid = 9'd3;
    req_valid = 1'b1; req_start_id = 9'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr_new_busy", 32'(busy), 1);
    chk("mr_new_start_id", 32'(start_id), 3);
    wait_for("mr_new_done", 3, 100);
    @(negedge clk);
    chk("mr_done_cnt", 32'(n_done - b_done), 1);

    // loop that never finishes on the 100-cycle-timeout instance
    req_valid_t = 1'b1;
    @(negedge clk);
    req_valid_t = 1'b0;
    chk("to_tbl_pulse", 32'(tbl_init_start_t), 1);
    @(negedge clk);
    tbl_done_t = 1'b1;
    @(negedge clk);
    tbl_done_t = 1'b0;
    chk("to_src_pulse", 32'(src_init_start_t), 1);
    @(negedge clk);
    src_done_t = 1'b1;
    @(negedge clk);
    src_done_t = 1'b0;
    chk("to_loop_pulse", 32'(loop_start_t), 1);
    n = 0;
    while (!timeout_err_t && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_loop_cycles", 32'(n), 100);
    chk("to_busy", 32'(busy_t), 0);
    chk("to_no_done", 32'(n_done_t), 0);
    chk("to_run_cycles", 32'(run_cycles_t), 0);
    req_valid_t = 1'b1;
    @(negedge clk);
    req_valid_t = 1'b0;
    chk("to_err_clear", 32'(timeout_err_t), 0);
    chk("to_rerun_busy", 32'(busy_t), 1);
    abort_t = 1'b1;
    @(negedge clk);
    abort_t = 1'b0;
    chk("to_abort_idle", 32'(busy_t), 0);

    chk("mux_mismatch", 32'(mux_bad), 0);
    chk("mux_coverage", 32'(mux_hits > 400), 1);
    chk("sid_hold_all", 32'(sid_bad), 0);
    chk("ready_busy_all", 32'(rdy_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
